// File: rtl/cacheline_arb_pkg.sv
// cacheline_arb_pkg: state encoding and sizing helpers shared by the cacheline arbiter adaptor
package cacheline_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  function automatic int beats(input int line_w, input int burst_w);
    return line_w / burst_w;
  endfunction
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the last grant
module rr_arbiter
  import cacheline_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW = cnt_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              valid
);
  always_comb begin
    grant = '0;
    idx = '0;
    valid = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!valid && req[(int'(last) + i) % NUM_CH]) begin
        valid = 1'b1;
        grant[(int'(last) + i) % NUM_CH] = 1'b1;
        idx = IW'((int'(last) + i) % NUM_CH);
      end
    end
  end
endmodule

// File: rtl/cacheline_arbiter_adaptor.sv
// cacheline_arbiter_adaptor: round-robin shares one burst memory port among NUM_CH line requesters
module cacheline_arbiter_adaptor
  import cacheline_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        read_i,
  input  logic [NUM_CH-1:0]        write_i,
  input  logic [NUM_CH*ADDR_W-1:0] address_i,
  input  logic [NUM_CH*LINE_W-1:0] line_i,
  output logic [LINE_W-1:0]        line_o,
  output logic [NUM_CH-1:0]        resp_o,
  input  logic [BURST_W-1:0]       burst_i,
  output logic [BURST_W-1:0]       burst_o,
  output logic [ADDR_W-1:0]        address_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic                     resp_i
);
  localparam int BEATS = beats(LINE_W, BURST_W);
  localparam int BW = cnt_w(BEATS);
  localparam int IW = cnt_w(NUM_CH);
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(LINE_W / 8 - 1);
  if (LINE_W % BURST_W != 0) begin : g_bad_width
    $error("LINE_W must be a multiple of BURST_W");
  end
  state_t state, nxt;
  logic [IW-1:0] last_grant, gidx;
  logic [NUM_CH-1:0] req, gnt, owner;
  logic gvalid, last_beat;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wline, rbuf, nbuf;
  assign req = read_i | write_i;
  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req(req),
    .last(last_grant),
    .grant(gnt),
    .idx(gidx),
    .valid(gvalid)
  );
  assign last_beat = resp_i && beat == BW'(BEATS - 1);
  always_comb begin
    nbuf = rbuf;
    nbuf[beat*BURST_W +: BURST_W] = burst_i;
    nxt = state == IDLE ? (gvalid ? (write_i[gidx] ? WRITE : READ) : IDLE)
        : state == DONE ? IDLE
        : last_beat ? DONE : state;
  end
  assign read_o = state == READ;
  assign write_o = state == WRITE;
  assign address_o = addr;
  assign burst_o = write_o ? wline[beat*BURST_W +: BURST_W] : '0;
  assign resp_o = state == DONE ? owner : '0;
  // line_o takes the completed line on the last beat so it is valid alongside resp_o
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= IW'(NUM_CH - 1);
      owner <= '0;
      beat <= '0;
      addr <= '0;
      wline <= '0;
      rbuf <= '0;
      line_o <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && gvalid) begin
        owner <= gnt;
        last_grant <= gidx;
        beat <= '0;
        addr <= address_i[gidx*ADDR_W +: ADDR_W] & AMASK;
        if (write_i[gidx]) wline <= line_i[gidx*LINE_W +: LINE_W];
      end else if ((state == READ || state == WRITE) && resp_i) begin
        beat <= beat + BW'(1);
        if (state == READ) rbuf <= nbuf;
        if (state == READ && last_beat) line_o <= nbuf;
      end
    end
  end
endmodule

// File: tb/tb_cacheline_arbiter_adaptor.sv
// tb_cacheline_arbiter_adaptor: directed and randomized checks against a transaction-level model
module tb_cacheline_arbiter_adaptor;
  logic clk = 1'b0, reset_n = 1'b0, resp_i = 1'b0;
  logic [1:0] read_i = '0, write_i = '0, resp_o;
  logic [63:0] address_i = '0, burst_i = '0, burst_o;
  logic [511:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0] address_o;
  logic read_o, write_o;
  int n_cmp = 0, n_err = 0, last;
  logic [255:0] exp_line;

  cacheline_arbiter_adaptor dut (
    .clk(clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int lst, input logic [1:0] rq);
    for (int i = 1; i <= 2; i++) if (rq[(lst + i) % 2]) return (lst + i) % 2;
    return -1;
  endfunction

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_zero(input string tag);
    chk({tag, "_read_o"}, read_o, 0);
    chk({tag, "_write_o"}, write_o, 0);
    chk({tag, "_resp_o"}, resp_o, 0);
  endtask

  // Entered at a negedge in IDLE with the request already presented; leaves at the next IDLE negedge.
  task automatic serve(input int ch, input bit wr, input logic [31:0] a, input logic [255:0] wl,
                       input logic [255:0] rl, input logic [15:0] gaps, input bit drop);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    @(negedge clk);
    if (drop) begin
      read_i[ch] = 1'b0;
      write_i[ch] = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= int'(gaps[b*4 +: 4]); g++) begin
        resp_i = (g == int'(gaps[b*4 +: 4]));
        burst_i = resp_i ? rl[b*64 +: 64] : {$urandom, $urandom};
        chk("read_o", read_o, !wr);
        chk("write_o", write_o, wr);
        chk("address_o", address_o, a);
        chk("resp_o_busy", resp_o, 0);
        if (wr) chk("burst_o", burst_o, wl[b*64 +: 64]);
        @(negedge clk);
      end
    end
    resp_i = 1'($urandom_range(0, 1));
    burst_i = {$urandom, $urandom};
    chk("resp_o_done", resp_o, oh);
    chk("done_read_o", read_o, 0);
    chk("done_write_o", write_o, 0);
    if (!wr) exp_line = rl;
    chk("line_o", line_o, exp_line);
    @(negedge clk);
    resp_i = 1'b0;
    idle_zero("idle");
    last = ch;
  endtask

  initial begin
    logic [255:0] rl, wl;
    logic [1:0] rd, wq;
    logic [15:0] gp;
    int ch;
    repeat (3) @(negedge clk);
    idle_zero("rst");
    chk("rst_line_o", line_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_address_o", address_o, 0);
    exp_line = '0;
    last = 1;
    reset_n = 1'b1;
    // single read on ch0
    read_i = 2'b01;
    address_i[31:0] = 32'h0000_1234;
    rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    serve(0, 0, 32'h0000_1220, '0, rl, 16'h0000, 0);
    read_i = 2'b00;
    // single write on ch1
    write_i = 2'b10;
    address_i[63:32] = 32'h8000_0040;
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    line_i[511:256] = wl;
    serve(1, 1, 32'h8000_0040, wl, '0, 16'h0000, 0);
    write_i = 2'b00;
    // both channels read continuously
    read_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ch = rr(last, read_i);
      chk("alternate", 32'(ch), 32'(k % 2));
      serve(ch, 0, address_i[ch*32 +: 32] & ~32'h1f, '0, r256(), 16'h0000, 0);
    end
    read_i = 2'b00;
    // gapped beats 1,0,0,1,1,0,1
    read_i = 2'b01;
    serve(0, 0, address_i[31:0] & ~32'h1f, '0, r256(), 16'h1020, 0);
    read_i = 2'b00;
    // reset in the middle of a read
    read_i = 2'b01;
    address_i[31:0] = 32'h0000_5000;
    @(negedge clk);
    resp_i = 1'b1;
    burst_i = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    idle_zero("mid_rst");
    chk("mid_rst_line_o", line_o, 0);
    chk("mid_rst_burst_o", burst_o, 0);
    chk("mid_rst_address_o", address_o, 0);
    read_i = 2'b00;
    resp_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_resp_o", resp_o, 0);
    reset_n = 1'b1;
    exp_line = '0;
    last = 1;
    read_i = 2'b10;
    address_i[63:32] = 32'h0000_9a7c;
    serve(1, 0, 32'h0000_9a60, '0, r256(), 16'h0000, 0);
    read_i = 2'b00;
    // read and write together on ch0: write wins
    read_i = 2'b01;
    write_i = 2'b01;
    wl = r256();
    line_i[255:0] = wl;
    serve(0, 1, address_i[31:0] & ~32'h1f, wl, '0, 16'h0000, 0);
    read_i = 2'b00;
    write_i = 2'b00;
    // memory strobes while idle are ignored
    resp_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_zero("idle_strobe");
    end
    resp_i = 1'b0;
    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      rd = 2'($urandom_range(0, 3));
      wq = 2'($urandom_range(0, 3));
      if ((rd | wq) == 2'b00) rd = 2'b01;
      read_i = rd;
      write_i = wq;
      address_i = {$urandom, $urandom};
      line_i = {r256(), r256()};
      for (int j = 0; j < 4; j++) gp[j*4 +: 4] = 4'($urandom_range(0, 2));
      ch = rr(last, rd | wq);
      serve(ch, wq[ch], address_i[ch*32 +: 32] & ~32'h1f, line_i[ch*256 +: 256], r256(), gp,
            1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
